// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit single-issue CPU: instruction width,
// opcode / funct encodings seen by the decoder, and the control sequencer
// state encoding.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INST_W = 16;

    // Major opcodes, instruction bits [15:12]
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LB    = 4'h2;
    localparam logic [3:0] OP_SB    = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_ANDI  = 4'h6;
    localparam logic [3:0] OP_ORI   = 4'h7;
    localparam logic [3:0] OP_RTYPE = 4'hF;

    // Within the NOP class, funct bits [2:0] select HALT
    localparam logic [2:0] FUNCT_HALT = 3'd1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/pc_counter.sv
// ----------------------------------------------------------------------------
// pc_counter
// Program counter register: resets to RESET_PC, increments by one when inc
// is high, wrapping naturally at 2^PC_W.
// Ports:
//   clk  in         system clock
//   rst  in         synchronous, active-high reset
//   inc  in         advance pc by one this cycle
//   pc   out [PC_W] current program counter
// ----------------------------------------------------------------------------
module pc_counter #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= PC_W'(RESET_PC);
        else if (inc)
            pc <= pc + PC_W'(1);   // modulo 2^PC_W by truncation
    end

endmodule

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control sequencer. Fetches into ir, lets the external decoder
// settle, then sequences EXEC / MEM / WB and gates the decoder's LD and MW
// strobes into rf_we and dmem_we so they only fire in their own phase.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start                        leave IDLE/HALT and (re)start fetching
//   imem_req/imem_addr/imem_ack  instruction fetch handshake, addr == pc
//   inst_in                      fetched instruction word
//   ir                           instruction register, feeds the decoder
//   dec_ld/mw/md/halt            decoder outputs for the current ir
//   dmem_req/dmem_we/dmem_ack    data memory handshake
//   rf_we                        register-file write strobe (WB only)
//   pc, retired                  program counter, completed-instruction count
//   busy, halted                 status
// ----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] inst_in,
    output logic [INST_W-1:0] ir,
    input  logic              dec_ld,
    input  logic              dec_mw,
    input  logic              dec_md,
    input  logic              dec_halt,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic              rf_we,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              halted
);

    seq_state_t state, state_nx;
    logic       ir_ld;
    logic       pc_inc;
    logic       retire;

    pc_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .inc (pc_inc),
        .pc  (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_nx;
            if (ir_ld)
                ir <= inst_in;
            if (retire)
                retired <= retired + 16'd1;
        end
    end

    // Acks are only examined in the state that raised the matching request,
    // so stray acks and acks arriving after a reset abort have no effect.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        retire   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_ld    = 1'b1;
                    pc_inc   = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                state_nx = dec_halt ? HALT : EXEC;
            end
            EXEC: begin
                if (dec_md || dec_mw) begin
                    state_nx = MEM;
                end else if (dec_ld) begin
                    state_nx = WB;
                end else begin
                    retire   = 1'b1;        // NOP-class completes here
                    state_nx = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mw;          // ir is stable, so we is held too
                if (dmem_ack) begin
                    if (dec_ld) begin
                        state_nx = WB;
                    end else begin
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            WB: begin
                rf_we    = 1'b1;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            HALT: begin
                if (start)
                    state_nx = FETCH;       // resume at the word after HALT
            end
            default: state_nx = IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                       (state == MEM)   || (state == WB);
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed bench for cpu_sequencer with a behavioural decoder beside it.
// Each instruction run pushes its expected outcome (latency, strobe counts,
// pc, retired, halted) to a scoreboard queue; the record is popped and
// compared once the sequencer returns to FETCH or reaches HALT.
// ----------------------------------------------------------------------------
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst, start;
    logic            imem_req, imem_ack;
    logic [PC_W-1:0] imem_addr, pc;
    logic [15:0]     inst_in, ir, retired;
    logic            dec_ld, dec_mw, dec_md, dec_halt;
    logic            dmem_req, dmem_we, dmem_ack;
    logic            rf_we, busy, halted;

    cpu_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .inst_in   (inst_in),
        .ir        (ir),
        .dec_ld    (dec_ld),
        .dec_mw    (dec_mw),
        .dec_md    (dec_md),
        .dec_halt  (dec_halt),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .rf_we     (rf_we),
        .pc        (pc),
        .retired   (retired),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Decoder model sitting beside the sequencer, driven from ir
    logic [3:0] op;
    assign op       = ir[15:12];
    assign dec_halt = (op == OP_NOP) && (ir[2:0] == FUNCT_HALT);
    assign dec_md   = (op == OP_LB);
    assign dec_mw   = (op == OP_SB);
    assign dec_ld   = (op == OP_LB) || (op == OP_ADDI) || (op == OP_ANDI) ||
                      (op == OP_ORI) || (op == OP_RTYPE);

    logic [15:0] mem [0:255];

    int passed = 0;
    int total  = 0;

    typedef struct {
        int cycles;
        int rf;
        int dm;
        int we;
        int pc;
        int ret;
        int hlt;
    } exp_t;

    exp_t sb_q[$];
    int   m_pc;
    int   m_ret;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the instruction at m_pc; the DUT must be in FETCH on entry.
    // iwait/dwait are wait cycles before the matching ack. Acks are driven
    // randomly whenever the matching request is low, and must be ignored.
    task automatic run_instr(input int iwait, input int dwait);
        exp_t        e;
        logic [15:0] w;
        logic [3:0]  o;
        int          cyc, rf, dm, we, icnt, dcnt;
        bit          left, done;

        w = mem[m_pc];
        o = w[15:12];
        e = '{default: 0};
        if (o == OP_NOP && w[2:0] == FUNCT_HALT) begin
            e.cycles = 2 + iwait; e.hlt = 1;
        end else if (o == OP_LB) begin
            e.cycles = 5 + iwait + dwait; e.rf = 1; e.dm = 1 + dwait; e.ret = 1;
        end else if (o == OP_SB) begin
            e.cycles = 4 + iwait + dwait; e.dm = 1 + dwait; e.we = 1 + dwait; e.ret = 1;
        end else if (o == OP_ADDI || o == OP_ANDI || o == OP_ORI || o == OP_RTYPE) begin
            e.cycles = 4 + iwait; e.rf = 1; e.ret = 1;
        end else begin
            e.cycles = 3 + iwait; e.ret = 1;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        m_pc  = (m_pc + 1) % 256;
        m_ret = (m_ret + e.ret) % 65536;
        e.pc  = m_pc;
        e.ret = m_ret;
        sb_q.push_back(e);

        cyc = 0; rf = 0; dm = 0; we = 0; icnt = 0; dcnt = 0;
        left = 1'b0; done = 1'b0;
        while (!done && cyc < 64) begin
            if (rf_we) rf++;
            if (dmem_req) begin
                dm++;
                if (dmem_we) we++;
            end
            if (imem_req) begin
                inst_in  = mem[imem_addr];
                imem_ack = (icnt >= iwait);
                if (icnt >= iwait) left = 1'b1;
                icnt++;
            end else begin
                inst_in  = 16'($urandom);
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                dmem_ack = (dcnt >= dwait);
                dcnt++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (left && (imem_req || halted)) done = 1'b1;
        end

        e = sb_q.pop_front();
        check("completed", 32'(done), 32'd1);
        check("latency", 32'(cyc), e.cycles);
        check("rf_we_cycles", 32'(rf), e.rf);
        check("dmem_req_cycles", 32'(dm), e.dm);
        check("dmem_we_cycles", 32'(we), e.we);
        check("pc", 32'(pc), e.pc);
        check("retired", 32'(retired), e.ret);
        check("halted", 32'(halted), e.hlt);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;   // asserted together with rst: rst must win
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        inst_in  = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'hF008;  // ADD
        mem[1] = 16'h2241;  // LB
        mem[2] = 16'h4241;  // SB
        mem[3] = 16'h0001;  // HALT
        mem[4] = 16'h5123;  // ADDI
        mem[5] = 16'h0000;  // NOP
        mem[6] = 16'h6A0F;  // ANDI
        mem[7] = 16'h7003;  // ORI

        step();
        start = 1'b0;
        step();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        rst = 1'b0;
        step();
        check("idle_wait", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);

        m_pc  = 0;
        m_ret = 0;
        run_instr(0, 0);   // ADD, zero wait
        run_instr(0, 3);   // LB, dmem_ack 3 cycles late
        run_instr(0, 0);   // SB
        run_instr(0, 0);   // HALT
        check("halt_ir", 32'(ir), 32'h0001);

        imem_ack = 1'b1;   // stray ack while halted
        dmem_ack = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check("halt_pc_frozen", 32'(pc), 32'd4);
        check("halt_stays", 32'(halted), 32'd1);
        check("halt_no_fetch", 32'(imem_req), 32'd0);
        check("halt_retired", 32'(retired), 32'd3);

        start = 1'b1;
        step();
        start = 1'b0;
        check("resume_addr", 32'(imem_addr), 32'd4);
        check("resume_halted", 32'(halted), 32'd0);

        run_instr(2, 0);   // ADDI, two fetch wait cycles
        run_instr(0, 0);   // NOP
        run_instr(1, 0);   // ANDI
        run_instr(0, 0);   // ORI

        // Sweep NOPs up to pc=255 and wrap; start held high must be ignored
        mem[0] = 16'h2241; // LB at the wrap target, used for the reset test
        start  = 1'b1;
        do run_instr(0, 0); while (m_pc != 0);
        start = 1'b0;
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_addr", 32'(imem_addr), 32'd0);

        // Reset during a MEM wait; the late ack must be ignored
        inst_in  = mem[imem_addr];
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        step();
        check("mem_req", 32'(dmem_req), 32'd1);
        check("mem_we_load", 32'(dmem_we), 32'd0);
        step();
        check("mem_req_held", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        dmem_ack = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dmem_req", 32'(dmem_req), 32'd0);
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_ir", 32'(ir), 32'd0);
        check("abort_retired", 32'(retired), 32'd0);
        step();
        step();
        dmem_ack = 1'b0;
        check("late_ack_busy", 32'(busy), 32'd0);
        check("late_ack_rf_we", 32'(rf_we), 32'd0);
        check("late_ack_retired", 32'(retired), 32'd0);
        check("late_ack_imem_req", 32'(imem_req), 32'd0);

        // rst and start together from IDLE: stays IDLE
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_beats_start", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_fetch", 32'(imem_req), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit single-issue CPU. It fetches instructions into the instruction register, presents the IR to the instruction decoder, and sequences execute, memory and writeback phases. It gates the decoder's register-load (LD) and memory-write (MW) strobes so they are asserted only in the correct phase, and handles HALT. It sits between the instruction/data memory handshakes and the register-file/ALU datapath.

## Interface
Parameters:
- PC_W, 8, program counter width; instruction address space is 2^PC_W words
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE or HALT and begin or resume fetching
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address; always equals pc
- imem_ack  in  1  fetch data valid on inst_in this cycle
- inst_in  in  16  instruction word from memory
- ir  out  16  instruction register, drives the decoder INST input
- dec_ld, dec_mw, dec_md, dec_halt  in  1 each  decoder LD, MW, MD, HALT for the current ir
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable; valid only while dmem_req=1
- dmem_ack  in  1  data memory transfer complete
- rf_we  out  1  register-file write strobe (gated LD)
- pc  out  PC_W  program counter
- retired  out  16  count of completed instructions
- busy  out  1  high in FETCH, DECODE, EXEC, MEM, WB
- halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is IDLE.
- IDLE: wait for start=1, then go to FETCH.
- FETCH: imem_req=1, held until imem_ack=1. On ack: ir<=inst_in, pc<=pc+1 modulo 2^PC_W, then go to DECODE.
- DECODE: one cycle so the decoder outputs settle.
  - dec_halt=1: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: one ALU cycle.
  - dec_md|dec_mw: go to MEM.
  - Else dec_ld: go to WB.
  - Else (NOP): retire, then go to FETCH.
- MEM: dmem_req=1, dmem_we=dec_mw, both held constant until dmem_ack=1. On ack:
  - dec_ld: go to WB.
  - Else: retire, then go to FETCH.
- WB: rf_we=1 for exactly one cycle, retire, then go to FETCH.
- HALT: halted=1, pc frozen. start=1 resumes at FETCH with the current pc (the address after the HALT word).
- Retire means retired<=retired+1, wrapping at 2^16. HALT and NOP-class encodings other than HALT: HALT is not counted; a NOP counts.
- Strobe gating:
  - rf_we is 0 outside WB.
  - dmem_req is 0 outside MEM.
  - imem_req is 0 outside FETCH.
- Ignored inputs:
  - imem_ack and dmem_ack are ignored when the matching request is low.
  - start is ignored when busy=1.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, ir=16'h0000, retired=0. All strobes (imem_req, dmem_req, dmem_we, rf_we) are 0; busy=0, halted=0.
- Acks may be asserted combinationally in the same cycle as the request (zero wait). Each wait cycle adds one cycle.
- Zero-wait latencies, measured from entering FETCH to re-entering FETCH:
  - ALU/immediate op: 4 cycles
  - NOP: 3 cycles
  - store: 4 cycles
  - load: 5 cycles
  - HALT: reaches HALT 2 cycles after entering FETCH
- ir, pc and retired are registered and change only on the edges listed above. Decoder-derived inputs are sampled only in DECODE, EXEC and MEM.
- pc wrap: pc=2^PC_W-1 fetches, then pc becomes 0. This is not an error.
- Reset mid-transaction (e.g. during MEM wait): the next cycle is IDLE with all strobes 0. The outstanding memory request is abandoned, and a late ack is ignored.
- start and rst asserted together: rst wins.

## Structure
- Shared package cpu_pkg holds:
  - seq_state_t enum (3-bit)
  - opcode constants OP_NOP=4'h0, OP_LB=4'h2, OP_SB=4'h4, OP_ADDI=4'h5, OP_ANDI=4'h6, OP_ORI=4'h7, OP_RTYPE=4'hF
  - FUNCT_HALT=3'd1
  - INST_W=16
- One natural sub-module: pc_counter (load, increment with wrap, reset to RESET_PC).
- The decoder is instantiated beside this block at the CPU top level, not inside it.

## Test plan
- Reset, then start; memory holds ADD 16'hF008 at pc 0 with zero-wait ack -> states FETCH, DECODE, EXEC, WB; rf_we high exactly 1 cycle; pc=1; retired=1.
- LB 16'h2241 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; then WB with rf_we=1; 8 cycles total.
- SB 16'h4241 -> dmem_req=1 and dmem_we=1 for one cycle; rf_we never asserted; next FETCH follows immediately.
- HALT 16'h0001 at pc 3 -> halted=1, pc=4, retired unchanged; start resumes FETCH at address 4.
- PC_W=8, pc=255 running NOPs -> after one fetch pc=0 and retired increments.
- rst asserted during a MEM wait, with dmem_ack arriving after reset -> IDLE, all outputs at reset values, ack ignored, retired=0.
